// File: rtl/wb_interconnect.sv
// Single-master, N-slave pipelined Wishbone decoder and response router.
// The request address is decoded against a base/mask map. The request is
// forwarded to one slave, and that slave's ack/stall/data are routed back.
// Unmapped addresses and slaves that never ack cause a one-cycle bus error,
// and the faulting address is captured.
module wb_interconnect #(
  parameter int                    NSLAVES    = 3,
  parameter logic [NSLAVES*32-1:0] SLAVE_BASE = {32'hc0000000, 32'hb0008000, 32'hb0000000},
  parameter logic [NSLAVES*32-1:0] SLAVE_MASK = {32'hffff0000, 32'hffff8000, 32'hffff8000},
  parameter int                    TIMEOUT    = 255,
  parameter int                    TIMEOUT_W  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_wb_cyc,
  input  logic                    i_wb_stb,
  input  logic                    i_wb_we,
  input  logic [31:0]             i_wb_addr,
  input  logic [31:0]             i_wb_data,
  input  logic [1:0]              i_width,
  output logic                    o_wb_ack,
  output logic                    o_wb_stall,
  output logic                    o_wb_err,
  output logic [31:0]             o_wb_data,
  output logic [31:0]             o_fault_addr,
  output logic [NSLAVES-1:0]      o_s_cyc,
  output logic [NSLAVES-1:0]      o_s_stb,
  output logic                    o_s_we,
  output logic [31:0]             o_s_addr,
  output logic [31:0]             o_s_data,
  output logic [1:0]              o_s_width,
  input  logic [NSLAVES-1:0]      i_s_ack,
  input  logic [NSLAVES-1:0]      i_s_stall,
  input  logic [NSLAVES*32-1:0]   i_s_data
);

  localparam int SEL_W = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;

  state_t               state_q, state_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic [31:0]          fault_q, fault_d;
  logic [31:0]          addr_q, addr_d;

  logic [NSLAVES-1:0]   match, winner;
  logic [SEL_W-1:0]     win_idx;
  logic                 found, mapped, req;

  logic [NSLAVES-1:0]   s_cyc, s_stb;
  logic                 ack, err, stall;
  logic [31:0]          rdata;

  // Per-slave address match.
  for (genvar k = 0; k < NSLAVES; k++) begin : g_match
    assign match[k] = ((i_wb_addr & SLAVE_MASK[32*k +: 32]) == SLAVE_BASE[32*k +: 32]);
  end

  // Priority pick: the lowest-index matching slave wins on overlapping maps.
  always_comb begin
    winner  = '0;
    win_idx = '0;
    found   = 1'b0;
    for (int k = 0; k < NSLAVES; k++) begin
      if (match[k] && !found) begin
        winner[k] = 1'b1;
        win_idx   = SEL_W'(k);
        found     = 1'b1;
      end
    end
  end

  assign mapped = |match;
  assign req    = i_wb_cyc & i_wb_stb;

  // Next-state logic and response routing for the IDLE/BUSY/ERR transaction FSM.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    addr_d  = addr_q;
    s_cyc   = '0;
    s_stb   = '0;
    ack     = 1'b0;
    err     = 1'b0;
    stall   = 1'b0;
    rdata   = '0;
    case (state_q)
      IDLE: begin
        s_cyc = req ? winner : '0;
        s_stb = req ? winner : '0;
        stall = mapped & i_s_stall[win_idx];
        if (req && !stall) begin
          addr_d = i_wb_addr;
          if (mapped) begin
            state_d = BUSY;
            sel_d   = win_idx;
            cnt_d   = '0;
          end else begin
            state_d = ERR;
            fault_d = i_wb_addr;
          end
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (!i_wb_cyc) begin
          // The master aborted, so the transaction is discarded without a response.
          state_d = IDLE;
        end else begin
          s_cyc[sel_q] = 1'b1;
          if (i_s_ack[sel_q]) begin
            // An ack in the timeout cycle still takes priority over the error.
            ack     = 1'b1;
            rdata   = i_s_data[sel_q*32 +: 32];
            state_d = IDLE;
          end else if (cnt_q == TIMEOUT_W'(TIMEOUT)) begin
            state_d = ERR;
            fault_d = addr_q;
          end else begin
            cnt_d = cnt_q + TIMEOUT_W'(1);
          end
        end
      end
      ERR: begin
        stall   = 1'b1;
        err     = i_wb_cyc;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers, with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      fault_q <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
      addr_q  <= addr_d;
    end
  end

  // Handshake outputs stay quiet for as long as reset is held low.
  assign o_s_cyc      = reset ? s_cyc : '0;
  assign o_s_stb      = reset ? s_stb : '0;
  assign o_wb_ack     = reset & ack;
  assign o_wb_err     = reset & err;
  assign o_wb_stall   = reset & stall;
  assign o_wb_data    = (reset & ack) ? rdata : 32'h0;
  assign o_fault_addr = fault_q;

  assign o_s_we    = i_wb_we;
  assign o_s_addr  = i_wb_addr;
  assign o_s_data  = i_wb_data;
  assign o_s_width = i_width;

endmodule

// File: tb/tb_wb_interconnect.sv
// Directed bench for wb_interconnect. The bench uses an overlapping map,
// where slave1 at 0xb0000000/64K covers slave0 at 0xb0000000/32K, and
// sets TIMEOUT to 4.
module tb_wb_interconnect;

  logic        clk = 1'b0;
  logic        reset;
  logic        cyc, stb, we;
  logic [31:0] addr, wdata;
  logic [1:0]  width;
  logic        wb_ack, wb_stall, wb_err;
  logic [31:0] wb_rdata, fault;
  logic [2:0]  s_cyc, s_stb;
  logic        s_we;
  logic [31:0] s_addr, s_wdata;
  logic [1:0]  s_width;
  logic [2:0]  s_ack, s_stall;
  logic [95:0] s_data;

  int total = 0;
  int bad   = 0;

  wb_interconnect #(
    .NSLAVES   (3),
    .SLAVE_BASE({32'hc0000000, 32'hb0000000, 32'hb0000000}),
    .SLAVE_MASK({32'hffff0000, 32'hffff0000, 32'hffff8000}),
    .TIMEOUT   (4),
    .TIMEOUT_W (8)
  ) dut (
    .clk(clk), .reset(reset),
    .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we), .i_wb_addr(addr),
    .i_wb_data(wdata), .i_width(width),
    .o_wb_ack(wb_ack), .o_wb_stall(wb_stall), .o_wb_err(wb_err),
    .o_wb_data(wb_rdata), .o_fault_addr(fault),
    .o_s_cyc(s_cyc), .o_s_stb(s_stb), .o_s_we(s_we), .o_s_addr(s_addr),
    .o_s_data(s_wdata), .o_s_width(s_width),
    .i_s_ack(s_ack), .i_s_stall(s_stall), .i_s_data(s_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  stall;
    logic [2:0]  exp_cyc;
    logic        exp_stall;
  } vec_t;
  vec_t vt[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vt[0] = '{32'hb0000010, 3'b000, 3'b001, 1'b0};
    vt[1] = '{32'hb0007ffc, 3'b000, 3'b001, 1'b0};
    vt[2] = '{32'hb0008004, 3'b000, 3'b010, 1'b0};
    vt[3] = '{32'hb000fffc, 3'b010, 3'b010, 1'b1};
    vt[4] = '{32'hb0000000, 3'b001, 3'b001, 1'b1};
    vt[5] = '{32'hb0000000, 3'b010, 3'b001, 1'b0};
    vt[6] = '{32'hc000abcd, 3'b100, 3'b100, 1'b1};
    vt[7] = '{32'hc0010000, 3'b111, 3'b000, 1'b0};
    vt[8] = '{32'ha0000000, 3'b000, 3'b000, 1'b0};
    vt[9] = '{32'hbfff0000, 3'b000, 3'b000, 1'b0};

    reset = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    width = 2'd0; s_ack = '0; s_stall = '0;
    s_data = {32'h22222222, 32'h11111111, 32'h00000000};

    // While reset is held, a live request must produce no bus activity.
    step; cyc = 1'b1; stb = 1'b1; addr = 32'hb0000010; #1;
    chk("rst_s_cyc", 32'(s_cyc), 32'h0);
    chk("rst_s_stb", 32'(s_stb), 32'h0);
    chk("rst_stall", 32'(wb_stall), 32'h0);
    chk("rst_ack", 32'(wb_ack), 32'h0);
    chk("rst_err", 32'(wb_err), 32'h0);
    step; #1;
    chk("rst_fault", fault, 32'h0);
    cyc = 1'b0; stb = 1'b0;
    step; reset = 1'b1;
    step;

    // Decode table, with each vector applied from IDLE.
    for (int i = 0; i < 10; i++) begin
      addr = vt[i].addr; s_stall = vt[i].stall; cyc = 1'b1; stb = 1'b1; #1;
      chk($sformatf("vec%0d_s_cyc", i), 32'(s_cyc), 32'(vt[i].exp_cyc));
      chk($sformatf("vec%0d_s_stb", i), 32'(s_stb), 32'(vt[i].exp_cyc));
      chk($sformatf("vec%0d_stall", i), 32'(wb_stall), 32'(vt[i].exp_stall));
      chk($sformatf("vec%0d_s_addr", i), s_addr, vt[i].addr);
      chk($sformatf("vec%0d_rdata", i), wb_rdata, 32'h0);
      step; cyc = 1'b0; stb = 1'b0; s_stall = '0;
      step; step;
    end

    // Read from slave0, which acks one cycle after acceptance.
    s_data[31:0] = 32'hdeadbeef;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 32'hb0000010; #1;
    chk("rd_s_cyc", 32'(s_cyc), 32'h1);
    chk("rd_idle_ack", 32'(wb_ack), 32'h0);
    chk("rd_idle_data", wb_rdata, 32'h0);
    step; stb = 1'b0; s_ack = 3'b001; #1;
    chk("rd_ack", 32'(wb_ack), 32'h1);
    chk("rd_data", wb_rdata, 32'hdeadbeef);
    chk("rd_busy_stb", 32'(s_stb), 32'h0);
    chk("rd_busy_cyc", 32'(s_cyc), 32'h1);
    chk("rd_busy_stall", 32'(wb_stall), 32'h1);
    step; s_ack = '0; cyc = 1'b0; #1;
    chk("rd_done_ack", 32'(wb_ack), 32'h0);
    chk("rd_done_data", wb_rdata, 32'h0);
    step;

    // Write to slave1, which stalls for two cycles.
    cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 32'hb0008004; wdata = 32'h12345678;
    s_stall = 3'b010;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk($sformatf("wr_stall%0d", c), 32'(wb_stall), 32'h1);
      chk($sformatf("wr_stb%0d", c), 32'(s_stb), 32'h2);
      chk($sformatf("wr_cyc%0d", c), 32'(s_cyc), 32'h2);
      step;
    end
    s_stall = '0; #1;
    chk("wr_go_stall", 32'(wb_stall), 32'h0);
    chk("wr_go_stb", 32'(s_stb), 32'h2);
    chk("wr_s_data", s_wdata, 32'h12345678);
    chk("wr_s_we", 32'(s_we), 32'h1);
    step; stb = 1'b0; s_ack = 3'b010; #1;
    chk("wr_ack", 32'(wb_ack), 32'h1);
    chk("wr_cyc_busy", 32'(s_cyc), 32'h2);
    step; s_ack = '0; #1;
    chk("wr_single_ack", 32'(wb_ack), 32'h0);
    cyc = 1'b0; we = 1'b0;
    step;

    // An unmapped access returns an error pulse and records the fault address.
    cyc = 1'b1; stb = 1'b1; addr = 32'hd0000000; #1;
    chk("um_s_cyc", 32'(s_cyc), 32'h0);
    chk("um_stall", 32'(wb_stall), 32'h0);
    chk("um_err_early", 32'(wb_err), 32'h0);
    step; stb = 1'b0; #1;
    chk("um_err", 32'(wb_err), 32'h1);
    chk("um_fault", fault, 32'hd0000000);
    chk("um_err_stall", 32'(wb_stall), 32'h1);
    step; #1;
    chk("um_err_once", 32'(wb_err), 32'h0);
    cyc = 1'b0;
    step;

    // Slave2 never acks, and slave0 acks spuriously; the error follows 5 BUSY cycles.
    cyc = 1'b1; stb = 1'b1; addr = 32'hc0000000; #1;
    chk("to_s_cyc", 32'(s_cyc), 32'h4);
    for (int c = 0; c < 5; c++) begin
      step; stb = 1'b0; s_ack = (c == 2) ? 3'b001 : 3'b000; #1;
      chk($sformatf("to_busy%0d_cyc", c), 32'(s_cyc), 32'h4);
      chk($sformatf("to_busy%0d_ack", c), 32'(wb_ack), 32'h0);
      chk($sformatf("to_busy%0d_err", c), 32'(wb_err), 32'h0);
    end
    step; s_ack = '0; #1;
    chk("to_err", 32'(wb_err), 32'h1);
    chk("to_s_cyc_drop", 32'(s_cyc), 32'h0);
    chk("to_fault", fault, 32'hc0000000);
    step; cyc = 1'b0; #1;
    chk("to_err_once", 32'(wb_err), 32'h0);
    step;

    // An ack that arrives when the counter reaches TIMEOUT takes priority over the error.
    s_data[95:64] = 32'hcafef00d;
    cyc = 1'b1; stb = 1'b1; addr = 32'hc0000000;
    for (int c = 0; c < 4; c++) begin
      step; stb = 1'b0; #1;
      chk($sformatf("ta_busy%0d_err", c), 32'(wb_err), 32'h0);
    end
    step; s_ack = 3'b100; #1;
    chk("ta_ack", 32'(wb_ack), 32'h1);
    chk("ta_data", wb_rdata, 32'hcafef00d);
    chk("ta_no_err", 32'(wb_err), 32'h0);
    step; s_ack = '0; #1;
    chk("ta_after_err", 32'(wb_err), 32'h0);
    chk("ta_idle_stall", 32'(wb_stall), 32'h0);
    cyc = 1'b0;
    step;

    // The master drops cyc while the FSM is in BUSY.
    cyc = 1'b1; stb = 1'b1; addr = 32'hb0000010;
    step; stb = 1'b0; cyc = 1'b0; s_ack = 3'b001; #1;
    chk("ab_s_cyc", 32'(s_cyc), 32'h0);
    chk("ab_ack", 32'(wb_ack), 32'h0);
    step; s_ack = '0; #1;
    chk("ab_err", 32'(wb_err), 32'h0);
    cyc = 1'b1; stb = 1'b1; addr = 32'hb0008004; #1;
    chk("ab_idle_stb", 32'(s_stb), 32'h2);
    chk("ab_idle_stall", 32'(wb_stall), 32'h0);
    step; stb = 1'b0; cyc = 1'b0;
    step;

    // Reset is asserted while the FSM is in BUSY.
    cyc = 1'b1; stb = 1'b1; addr = 32'hb0000010;
    step; stb = 1'b0; reset = 1'b0; s_ack = 3'b001; #1;
    chk("rb_s_cyc", 32'(s_cyc), 32'h0);
    chk("rb_ack", 32'(wb_ack), 32'h0);
    chk("rb_stall", 32'(wb_stall), 32'h0);
    step; reset = 1'b1; s_ack = '0; #1;
    chk("rb_fault", fault, 32'h0);
    chk("rb_err", 32'(wb_err), 32'h0);
    chk("rb_idle_stall", 32'(wb_stall), 32'h0);
    chk("rb_idle_cyc", 32'(s_cyc), 32'h0);
    cyc = 1'b0;
    step;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
